// File: rtl/core_pkg.sv
// Shared core types: data width, byte-mask width, memory request kinds
// and the data-memory responder state encoding.
package core_pkg;

    localparam int Xlen     = 64;
    localparam int MaskBits = Xlen / 8;

    typedef enum logic [1:0] {
        MemNone  = 2'd0,
        MemLoad  = 2'd1,
        MemStore = 2'd2
    } mem_type_e;

    typedef enum logic [1:0] {
        DmemIdle = 2'd0,
        DmemWait = 2'd1,
        DmemResp = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with byte-masked synchronous write and
// asynchronous read; contents are never reset.
module dmem_array
    import core_pkg::*;
#(
    parameter int Depth    = 1024,
    parameter int AddrBits = $clog2(Depth)
) (
    input  logic                clock,
    input  logic                writeEn,
    input  logic [AddrBits-1:0] addr,
    input  logic [Xlen-1:0]     writeData,
    input  logic [MaskBits-1:0] writeMask,
    output logic [Xlen-1:0]     readData
);

    logic [Xlen-1:0] mem [Depth];

    // Only bytes whose enable is set are touched; an all-zero mask is a no-op.
    always_ff @(posedge clock) begin
        if (writeEn) begin
            for (int b = 0; b < MaskBits; b++) begin
                if (writeMask[b]) begin
                    mem[addr][b*8 +: 8] <= writeData[b*8 +: 8];
                end
            end
        end
    end

    assign readData = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, fixed wait latency, held
// response. Define DMEM_RANGE_CHECK_EN to flag out-of-range addresses.
module dmem_responder
    import core_pkg::*;
#(
    parameter int Depth   = 1024,
    parameter int Latency = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  mem_type_e           req_type_i,
    input  logic [Xlen-1:0]     req_addr_i,
    input  logic [Xlen-1:0]     req_wdata_i,
    input  logic [MaskBits-1:0] req_wmask_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [Xlen-1:0]     rsp_rdata_o,
    output logic                rsp_err_o
);

    localparam int         AddrBits = $clog2(Depth);
    localparam logic [3:0] CountMax = (Latency > 0) ? 4'(Latency - 1) : 4'd0;

    dmem_state_e         state;
    logic [3:0]          count;
    logic                readyReg;
    logic                accept;
    logic                rangeErr;
    logic                writeEn;
    logic [AddrBits-1:0] wordIdx;
    logic [Xlen-1:0]     arrayData;
    logic                unusedAddrBits;

    assign req_ready_o    = readyReg && !rst_i;
    assign accept         = req_valid_i && req_ready_o;
    assign wordIdx        = req_addr_i[3 +: AddrBits];
    assign unusedAddrBits = ^req_addr_i;

`ifdef DMEM_RANGE_CHECK_EN
    assign rangeErr = (req_addr_i >= Xlen'(Depth * MaskBits));
`else
    assign rangeErr = 1'b0;
`endif

    assign writeEn = accept && (req_type_i == MemStore) && !rangeErr;

    dmem_array #(
        .Depth    (Depth),
        .AddrBits (AddrBits)
    ) array (
        .clock     (clk_i),
        .writeEn   (writeEn),
        .addr      (wordIdx),
        .writeData (req_wdata_i),
        .writeMask (req_wmask_i),
        .readData  (arrayData)
    );

    // Load data is captured at acceptance, so the response is immune to any
    // later write and stays stable while the consumer stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= DmemIdle;
            count       <= 4'd0;
            readyReg    <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state)
                DmemIdle: begin
                    if (accept) begin
                        readyReg    <= 1'b0;
                        count       <= 4'd0;
                        rsp_err_o   <= rangeErr;
                        rsp_rdata_o <= ((req_type_i == MemLoad) && !rangeErr) ? arrayData : '0;
                        if (Latency == 0) begin
                            state       <= DmemResp;
                            rsp_valid_o <= 1'b1;
                        end else begin
                            state <= DmemWait;
                        end
                    end
                end
                DmemWait: begin
                    if (count == CountMax) begin
                        count       <= 4'd0;
                        state       <= DmemResp;
                        rsp_valid_o <= 1'b1;
                    end else begin
                        count <= count + 4'd1;
                    end
                end
                DmemResp: begin
                    if (rsp_ready_i) begin
                        state       <= DmemIdle;
                        rsp_valid_o <= 1'b0;
                        readyReg    <= 1'b1;
                    end
                end
                default: begin
                    state       <= DmemIdle;
                    count       <= 4'd0;
                    readyReg    <= 1'b1;
                    rsp_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (Latency 1, 0, 15) driven through
// a scoreboard fed by a reference memory model.
module tb_dmem_responder;
    import core_pkg::*;

    typedef struct {
        logic [Xlen-1:0] rdata;
        logic            err;
        int              lat;
    } exp_t;

    logic            clock = 1'b0;
    logic            rst       [3];
    logic            reqValid  [3];
    logic            reqReady  [3];
    mem_type_e       reqType   [3];
    logic [Xlen-1:0] reqAddr   [3];
    logic [Xlen-1:0] reqWdata  [3];
    logic [7:0]      reqWmask  [3];
    logic            rspValid  [3];
    logic            rspReady  [3];
    logic [Xlen-1:0] rspRdata  [3];
    logic            rspErr    [3];

    int              lat [3] = '{1, 0, 15};
    logic [Xlen-1:0] modelMem [3][1024];
    exp_t            sb [$];
    int              total = 0;
    int              bad   = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : dut
        dmem_responder #(
            .Depth   (1024),
            .Latency ((g == 0) ? 1 : ((g == 1) ? 0 : 15))
        ) u (
            .clk_i       (clock),
            .rst_i       (rst[g]),
            .req_valid_i (reqValid[g]),
            .req_ready_o (reqReady[g]),
            .req_type_i  (reqType[g]),
            .req_addr_i  (reqAddr[g]),
            .req_wdata_i (reqWdata[g]),
            .req_wmask_i (reqWmask[g]),
            .rsp_valid_o (rspValid[g]),
            .rsp_ready_i (rspReady[g]),
            .rsp_rdata_o (rspRdata[g]),
            .rsp_err_o   (rspErr[g])
        );
    end

    function automatic bit outOfRange(input logic [Xlen-1:0] a);
`ifdef DMEM_RANGE_CHECK_EN
        return a >= 64'd8192;
`else
        return 1'b0;
`endif
    endfunction

    // Drives one request, pushes the model's expectation, waits for acceptance
    // and then for rsp_valid; returns at a negedge with the response held.
    task automatic applyStimulus(input int u, input mem_type_e t, input logic [Xlen-1:0] a,
                                 input logic [Xlen-1:0] w, input logic [7:0] m,
                                 output int cycles, output bit timedOut);
        exp_t e;
        int   idx;
        int   waitN;
        idx     = int'(a[12:3]);
        e.err   = outOfRange(a);
        e.rdata = '0;
        e.lat   = lat[u] + 1;
        if (!e.err) begin
            if (t == MemStore) begin
                for (int b = 0; b < 8; b++)
                    if (m[b]) modelMem[u][idx][b*8 +: 8] = w[b*8 +: 8];
            end else if (t == MemLoad) begin
                e.rdata = modelMem[u][idx];
            end
        end
        sb.push_back(e);
        @(negedge clock);
        reqValid[u] = 1'b1;
        reqType[u]  = t;
        reqAddr[u]  = a;
        reqWdata[u] = w;
        reqWmask[u] = m;
        waitN = 0;
        while (!reqReady[u] && waitN < 40) begin
            @(negedge clock);
            waitN++;
        end
        cycles   = 0;
        timedOut = 1'b1;
        if (!reqReady[u]) begin
            reqValid[u] = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        reqValid[u] = 1'b0;
        reqType[u]  = MemNone;
        cycles = 1;
        @(negedge clock);
        while (!rspValid[u] && cycles < 100) begin
            @(posedge clock);
            cycles++;
            @(negedge clock);
        end
        timedOut = !rspValid[u];
    endtask

    task automatic releaseRsp(input int u);
        rspReady[u] = 1'b1;
        @(posedge clock);
        #1;
        rspReady[u] = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int u = 0; u < 3; u++) begin
            total++;
            if (reqReady[u] !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_ready u=%0d got=%b want=0", u, reqReady[u]);
            end
            total++;
            if (rspValid[u] !== 1'b0 || rspErr[u] !== 1'b0 || rspRdata[u] !== '0) begin
                bad++;
                $display("[TB] FAIL reset_rsp u=%0d got valid=%b err=%b rdata=%h want 0/0/0",
                         u, rspValid[u], rspErr[u], rspRdata[u]);
            end
            rst[u] = 1'b0;
        end
        @(negedge clock);
        for (int u = 0; u < 3; u++) begin
            total++;
            if (reqReady[u] !== 1'b1) begin
                bad++;
                $display("[TB] FAIL post_reset_ready u=%0d got=%b want=1", u, reqReady[u]);
            end
        end
    endtask

    task automatic test_store_load();
        mem_type_e       tt [7] = '{MemStore, MemLoad, MemStore, MemLoad, MemStore, MemLoad, MemNone};
        logic [Xlen-1:0] ww [7] = '{64'h1122334455667788, 64'h0, 64'hAAAAAAAAAAAAAAAA,
                                    64'h0, 64'hDEADBEEFDEADBEEF, 64'h0, 64'h5555};
        logic [7:0]      mm [7] = '{8'hFF, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 8'hFF};
        int   cyc;
        bit   to;
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, tt[i], 64'h10, ww[i], mm[i], cyc, to);
            e = sb.pop_front();
            total++;
            if (to || cyc != e.lat || rspRdata[0] !== e.rdata || rspErr[0] !== e.err) begin
                bad++;
                $display("[TB] FAIL store_load[%0d] got to=%0b lat=%0d rdata=%h err=%b want lat=%0d rdata=%h err=%b",
                         i, to, cyc, rspRdata[0], rspErr[0], e.lat, e.rdata, e.err);
            end
            releaseRsp(0);
        end
        total++;
        if (modelMem[0][2] !== 64'h11223344AAAAAAAA) begin
            bad++;
            $display("[TB] FAIL mask_model got=%h want=11223344aaaaaaaa", modelMem[0][2]);
        end
    endtask

    task automatic test_hold();
        int   cyc;
        bit   to;
        exp_t e;
        int   unstable;
        applyStimulus(0, MemStore, 64'h20, 64'h0123456789ABCDEF, 8'hFF, cyc, to);
        void'(sb.pop_front());
        releaseRsp(0);
        applyStimulus(0, MemLoad, 64'h20, 64'h0, 8'h00, cyc, to);
        e = sb.pop_front();
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            if (rspValid[0] !== 1'b1 || rspRdata[0] !== e.rdata || reqReady[0] !== 1'b0
                || rspErr[0] !== e.err)
                unstable++;
            @(negedge clock);
        end
        total++;
        if (to || unstable != 0) begin
            bad++;
            $display("[TB] FAIL hold_stable got to=%0b unstableCycles=%0d rdata=%h want 0 unstable rdata=%h",
                     to, unstable, rspRdata[0], e.rdata);
        end
        rspReady[0] = 1'b1;
        @(posedge clock);
        #1;
        rspReady[0] = 1'b0;
        @(negedge clock);
        total++;
        if (rspValid[0] !== 1'b0 || reqReady[0] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL hold_release got valid=%b ready=%b want valid=0 ready=1",
                     rspValid[0], reqReady[0]);
        end
    endtask

    task automatic test_latency();
        int   cyc;
        bit   to;
        exp_t e;
        for (int u = 1; u < 3; u++) begin
            applyStimulus(u, MemStore, 64'h40, 64'hCAFEF00D00000000 + 64'(u), 8'hFF, cyc, to);
            e = sb.pop_front();
            total++;
            if (to || cyc != e.lat || rspErr[u] !== e.err) begin
                bad++;
                $display("[TB] FAIL latency_store u=%0d got lat=%0d to=%0b want lat=%0d", u, cyc, to, e.lat);
            end
            releaseRsp(u);
            applyStimulus(u, MemLoad, 64'h47, 64'h0, 8'h00, cyc, to);
            e = sb.pop_front();
            total++;
            if (to || cyc != e.lat || rspRdata[u] !== e.rdata) begin
                bad++;
                $display("[TB] FAIL latency_load u=%0d got lat=%0d rdata=%h want lat=%0d rdata=%h",
                         u, cyc, rspRdata[u], e.lat, e.rdata);
            end
            releaseRsp(u);
        end
    endtask

    task automatic test_range();
        mem_type_e       tt [4] = '{MemStore, MemStore, MemLoad, MemLoad};
        logic [Xlen-1:0] aa [4] = '{64'h0, 64'h2000, 64'h0, 64'h2000};
        logic [Xlen-1:0] ww [4] = '{64'h0A0A0A0A0A0A0A0A, 64'hB0B0B0B0B0B0B0B0, 64'h0, 64'h0};
        int   cyc;
        bit   to;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, tt[i], aa[i], ww[i], 8'hFF, cyc, to);
            e = sb.pop_front();
            total++;
            if (to || rspRdata[0] !== e.rdata || rspErr[0] !== e.err) begin
                bad++;
                $display("[TB] FAIL range[%0d] got rdata=%h err=%b want rdata=%h err=%b",
                         i, rspRdata[0], rspErr[0], e.rdata, e.err);
            end
            releaseRsp(0);
        end
    endtask

    task automatic test_reset_wait();
        int   cyc;
        bit   to;
        exp_t e;
        int   seen;
        @(negedge clock);
        reqValid[2] = 1'b1;
        reqType[2]  = MemStore;
        reqAddr[2]  = 64'h18;
        reqWdata[2] = 64'h8877665544332211;
        reqWmask[2] = 8'hFF;
        modelMem[2][3] = 64'h8877665544332211;
        @(posedge clock);
        #1;
        reqValid[2] = 1'b0;
        reqType[2]  = MemNone;
        repeat (3) @(negedge clock);
        rst[2] = 1'b1;
        @(negedge clock);
        total++;
        if (rspValid[2] !== 1'b0 || reqReady[2] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_wait_during got valid=%b ready=%b want 0/0", rspValid[2], reqReady[2]);
        end
        rst[2] = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (rspValid[2] === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("[TB] FAIL reset_wait_discard got validCycles=%0d want 0", seen);
        end
        applyStimulus(2, MemLoad, 64'h18, 64'h0, 8'h00, cyc, to);
        e = sb.pop_front();
        total++;
        if (to || rspRdata[2] !== e.rdata || cyc != e.lat) begin
            bad++;
            $display("[TB] FAIL reset_wait_commit got rdata=%h lat=%0d want rdata=%h lat=%0d",
                     rspRdata[2], cyc, e.rdata, e.lat);
        end
        releaseRsp(2);
    endtask

    task automatic test_back_to_back();
        int              cyc;
        bit              to;
        exp_t            e;
        mem_type_e       t;
        logic [Xlen-1:0] a;
        for (int i = 0; i < 20; i++) begin
            a = 64'(i % 8) << 3;
            if (i < 8) t = MemStore;
            else t = ($urandom_range(0, 1) == 0) ? MemLoad : MemStore;
            applyStimulus(1, t, a, {$urandom, $urandom}, 8'($urandom), cyc, to);
            e = sb.pop_front();
            total++;
            if (to || cyc != e.lat || rspRdata[1] !== e.rdata || rspErr[1] !== e.err) begin
                bad++;
                $display("[TB] FAIL b2b[%0d] got lat=%0d rdata=%h err=%b want lat=%0d rdata=%h err=%b",
                         i, cyc, rspRdata[1], rspErr[1], e.lat, e.rdata, e.err);
            end
            releaseRsp(1);
        end
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            rst[u]      = 1'b1;
            reqValid[u] = 1'b0;
            reqType[u]  = MemNone;
            reqAddr[u]  = '0;
            reqWdata[u] = '0;
            reqWmask[u] = '0;
            rspReady[u] = 1'b0;
            for (int j = 0; j < 1024; j++) modelMem[u][j] = '0;
        end
        test_reset();
        test_store_load();
        test_hold();
        test_latency();
        test_range();
        test_reset_wait();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

endmodule
